// File: rtl/arb8_rr.sv
// Eight-way round-robin arbiter with registered one-hot grant, a fairness
// pointer that advances past each released owner, and an optional hold limit.
module arb8_rr #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       any_req,
    output logic       preempt
);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        GAP
    } state_e;

    state_e           state_q,    state_d;
    logic [7:0]       gnt_q,      gnt_d;
    logic [2:0]       gnt_idx_q,  gnt_idx_d;
    logic [2:0]       ptr_q,      ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             preempt_q,  preempt_d;

    logic [2:0] win_idx;
    logic [2:0] cand;
    logic       owner_req;
    logic       hold_hit;
    logic       release_now;

    assign any_req     = |req;
    assign owner_req   = req[gnt_idx_q];
    assign hold_hit    = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD));
    assign release_now = !owner_req || hold_hit;

    // Scan from the farthest slot back towards ptr so the last hit is the
    // first requester in circular order starting at ptr.
    always_comb begin
        win_idx = '0;
        cand    = '0;
        for (int unsigned k = 8; k > 0; k--) begin
            cand = ptr_q + 3'(k - 1);
            if (req[cand]) begin
                win_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            preempt_q  <= preempt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = OWN;
            OWN:     if (release_now) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d      = 8'b1 << win_idx;
                    gnt_idx_d  = win_idx;
                    hold_cnt_d = CNT_W'(1);
                end
            end
            OWN: begin
                if (release_now) begin
                    gnt_d      = '0;
                    gnt_idx_d  = '0;
                    ptr_d      = gnt_idx_q + 3'd1;
                    hold_cnt_d = '0;
                    // A coincident deassert is a normal release, not a preemption.
                    preempt_d  = owner_req;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = |gnt_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_arb8_rr.sv
// Directed bench for arb8_rr: three instances (default, hold limit 4, unlimited)
// share clock and reset; each scenario task drives one instance and checks inline.
module tb_arb8_rr;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_a, req_b, req_c;
    logic [7:0] gnt_a, gnt_b, gnt_c;
    logic [2:0] idx_a, idx_b, idx_c;
    logic       val_a, val_b, val_c;
    logic       any_a, any_b, any_c;
    logic       pre_a, pre_b, pre_c;

    int checks;
    int errors;
    int inv_viol;
    int run_b;

    arb8_rr u_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .gnt(gnt_a), .gnt_idx(idx_a),
        .gnt_valid(val_a), .any_req(any_a), .preempt(pre_a)
    );

    arb8_rr #(.MAX_HOLD(4), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b), .gnt_idx(idx_b),
        .gnt_valid(val_b), .any_req(any_b), .preempt(pre_b)
    );

    arb8_rr #(.MAX_HOLD(0), .CNT_W(8)) u_c (
        .clk(clk), .rst_n(rst_n), .req(req_c), .gnt(gnt_c), .gnt_idx(idx_c),
        .gnt_valid(val_c), .any_req(any_c), .preempt(pre_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit inv_ok(input logic [7:0] g, input logic [2:0] i,
                                  input logic v, input logic p);
        bit ok;
        ok = ($countones(g) <= 1) && (v === (|g));
        if (v) ok = ok && (g === (8'b1 << i));
        else   ok = ok && (i === 3'd0);
        if (p) ok = ok && !v;
        return ok;
    endfunction

    always @(negedge clk) begin
        if (!inv_ok(gnt_a, idx_a, val_a, pre_a)) inv_viol++;
        if (!inv_ok(gnt_b, idx_b, val_b, pre_b)) inv_viol++;
        if (!inv_ok(gnt_c, idx_c, val_c, pre_c)) inv_viol++;
        if (val_b) run_b++;
        else       run_b = 0;
        if (run_b > 4) inv_viol++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_a = '0;
        req_b = '0;
        req_c = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_a = 8'hFF;
        req_b = '0;
        req_c = '0;
        tick();
        tick();
        tick();
        checks++;
        if (gnt_a !== 8'h00 || val_a !== 1'b0 || pre_a !== 1'b0 || idx_a !== 3'd0) begin
            errors++;
            $display("FAIL reset_hold: gnt=%h valid=%b preempt=%b idx=%0d, want 00 0 0 0",
                     gnt_a, val_a, pre_a, idx_a);
        end
        checks++;
        if (any_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_any_req: got %b want 1", any_a);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (gnt_a !== 8'h01 || idx_a !== 3'd0 || val_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: gnt=%h idx=%0d valid=%b, want 01 0 1",
                     gnt_a, idx_a, val_a);
        end
    endtask

    task automatic test_single();
        do_reset();
        req_a = 8'h10;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (gnt_a !== 8'h10 || idx_a !== 3'd4) begin
                errors++;
                $display("FAIL single_hold[%0d]: gnt=%h idx=%0d, want 10 4", i, gnt_a, idx_a);
            end
        end
        req_a = 8'h00;
        tick();
        checks++;
        if (gnt_a !== 8'h00 || val_a !== 1'b0) begin
            errors++;
            $display("FAIL single_gap: gnt=%h valid=%b, want 00 0", gnt_a, val_a);
        end
        // ptr should now be 5: bit 5 must beat bit 0.
        req_a = 8'h21;
        tick();
        checks++;
        if (gnt_a !== 8'h00) begin
            errors++;
            $display("FAIL single_idle: gnt=%h, want 00", gnt_a);
        end
        tick();
        checks++;
        if (gnt_a !== 8'h20 || idx_a !== 3'd5) begin
            errors++;
            $display("FAIL single_ptr5: gnt=%h idx=%0d, want 20 5", gnt_a, idx_a);
        end
        req_a = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_fairness();
        int owner;
        do_reset();
        req_a = 8'hFF;
        for (int n = 0; n < 9; n++) begin
            owner = n % 8;
            for (int c = 0; c < 2; c++) begin
                tick();
                checks++;
                if (gnt_a !== (8'b1 << owner) || idx_a !== 3'(owner)) begin
                    errors++;
                    $display("FAIL rr_grant[%0d.%0d]: gnt=%h idx=%0d, want %h %0d",
                             n, c, gnt_a, idx_a, 8'b1 << owner, owner);
                end
            end
            req_a = 8'hFF & ~(8'b1 << owner);
            tick();
            checks++;
            if (gnt_a !== 8'h00) begin
                errors++;
                $display("FAIL rr_gap[%0d]: gnt=%h, want 00", n, gnt_a);
            end
            req_a = 8'hFF;
            tick();
            checks++;
            if (gnt_a !== 8'h00) begin
                errors++;
                $display("FAIL rr_idle[%0d]: gnt=%h, want 00", n, gnt_a);
            end
        end
        req_a = 8'h00;
        tick();
        tick();
        tick();
    endtask

    task automatic test_preempt();
        logic [7:0] exp_g;
        do_reset();
        req_b = 8'h06;
        for (int r = 0; r < 3; r++) begin
            exp_g = (r == 1) ? 8'h04 : 8'h02;
            for (int c = 0; c < 4; c++) begin
                tick();
                checks++;
                if (gnt_b !== exp_g || pre_b !== 1'b0) begin
                    errors++;
                    $display("FAIL pre_own[%0d.%0d]: gnt=%h preempt=%b, want %h 0",
                             r, c, gnt_b, pre_b, exp_g);
                end
            end
            if (r == 2) begin
                // owner drops on the limit edge: normal release, no preempt
                req_b = 8'h04;
            end
            tick();
            checks++;
            if (gnt_b !== 8'h00 || pre_b !== ((r == 2) ? 1'b0 : 1'b1)) begin
                errors++;
                $display("FAIL pre_release[%0d]: gnt=%h preempt=%b, want 00 %b",
                         r, gnt_b, pre_b, (r == 2) ? 1'b0 : 1'b1);
            end
            tick();
            checks++;
            if (gnt_b !== 8'h00 || pre_b !== 1'b0) begin
                errors++;
                $display("FAIL pre_idle[%0d]: gnt=%h preempt=%b, want 00 0", r, gnt_b, pre_b);
            end
        end
        req_b = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_wrap_unlimited();
        int bad;
        do_reset();
        req_c = 8'h40;
        tick();
        checks++;
        if (gnt_c !== 8'h40) begin
            errors++;
            $display("FAIL wrap_own6: gnt=%h, want 40", gnt_c);
        end
        req_c = 8'h81;
        req_c[6] = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (gnt_c !== 8'h80 || idx_c !== 3'd7) begin
            errors++;
            $display("FAIL wrap_grant7: gnt=%h idx=%0d, want 80 7", gnt_c, idx_c);
        end
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (gnt_c !== 8'h80 || pre_c !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL unlimited_hold: %0d bad cycles of 300, want 0", bad);
        end
        req_c = 8'h01;
        tick();
        checks++;
        if (gnt_c !== 8'h00 || pre_c !== 1'b0) begin
            errors++;
            $display("FAIL wrap_release: gnt=%h preempt=%b, want 00 0", gnt_c, pre_c);
        end
        tick();
        tick();
        checks++;
        if (gnt_c !== 8'h01 || idx_c !== 3'd0) begin
            errors++;
            $display("FAIL wrap_to0: gnt=%h idx=%0d, want 01 0", gnt_c, idx_c);
        end
        req_c = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        req_a = 8'h08;
        tick();
        checks++;
        if (gnt_a !== 8'h08) begin
            errors++;
            $display("FAIL async_pre: gnt=%h, want 08", gnt_a);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt_a !== 8'h00 || val_a !== 1'b0 || idx_a !== 3'd0) begin
            errors++;
            $display("FAIL async_clear: gnt=%h valid=%b idx=%0d, want 00 0 0",
                     gnt_a, val_a, idx_a);
        end
        #1;
        rst_n = 1'b1;
        req_a = 8'h88;
        tick();
        checks++;
        if (gnt_a !== 8'h08 || idx_a !== 3'd3) begin
            errors++;
            $display("FAIL async_ptr0: gnt=%h idx=%0d, want 08 3", gnt_a, idx_a);
        end
        req_a = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_invariants();
        checks++;
        if (inv_viol !== 0) begin
            errors++;
            $display("FAIL invariants: %0d violations, want 0", inv_viol);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        inv_viol = 0;
        run_b    = 0;
        rst_n    = 1'b0;
        req_a    = '0;
        req_b    = '0;
        req_c    = '0;
        test_reset();
        test_single();
        test_fairness();
        test_preempt();
        test_wrap_unlimited();
        test_async_reset();
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb8_rr.md
Name: arb8_rr

Overview:
- Round-robin arbiter that shares one datapath resource (e.g., the ALU result bus) among 8 requesters.
- Grants are registered and one-hot. A grant is held while its requester keeps requesting, and it is force-released after a programmable hold limit.
- The any-request term is the 8-input OR of the request lines (or8way structure). This block adds the sequencing, fairness pointer and hold timer around it.

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles per ownership; 0 = unlimited; legal range 0..255.
- CNT_W, 8, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request lines; bit i = requester i; level-sensitive.
- gnt  output  8  registered one-hot grant; all zero when no owner.
- gnt_idx  output  3  binary index of current owner; 0 when gnt_valid=0.
- gnt_valid  output  1  high while any gnt bit is set.
- any_req  output  1  combinational OR of req[7:0].
- preempt  output  1  one-cycle pulse on the cycle a grant is force-released by the hold limit.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, ptr=0, hold_cnt=0. Outputs clear immediately, without waiting for a clock edge. Release is synchronous to clk.
- Reset mid-grant drops the grant immediately. After reset, ptr=0 and no history is kept.
- States: IDLE, OWN, GAP.
- IDLE: if any_req=1 at a rising edge, select winner w = first i in circular order ptr, ptr+1, ..., ptr+7 (mod 8) with req[i]=1. On that same edge: gnt=onehot(w), gnt_idx=w, gnt_valid=1, hold_cnt=1, state=OWN. Latency from req to gnt is 1 cycle. If any_req=0, stay in IDLE.
- OWN, normal release: when req[gnt_idx]=0 at an edge, then on that edge gnt=0, gnt_valid=0, gnt_idx=0, ptr=(w+1) mod 8, state=GAP.
- OWN, forced release: when MAX_HOLD!=0, req[gnt_idx]=1 and hold_cnt==MAX_HOLD at an edge, the release is identical to a normal release plus preempt=1 for exactly the following cycle.
- OWN, otherwise: hold_cnt increments. With MAX_HOLD=0 the counter saturates at all-ones and never wraps.
- Maximum grant duration is therefore MAX_HOLD cycles.
- GAP: exactly one turnaround cycle with no grant and no arbitration. Next state is IDLE, which re-arbitrates on the following edge.
- Minimum gap between consecutive grants is 2 idle-grant cycles (GAP + IDLE), re-evaluated with the updated ptr.
- Requests from non-owners are ignored while in OWN or GAP. They are not latched, so a requester must hold req high until granted.
- A request bit that rises and falls entirely within OWN/GAP is lost by design.
- Priority: ptr is updated only on release and always points one past the last owner. Worst-case wait for a continuously requesting line is 7 ownerships.
- Wrap-around: owner 7 releases → ptr=0.
- Simultaneous events:
  - Owner deassert coinciding with the hold limit counts as a normal release; preempt stays 0.
  - Requests rising in the GAP cycle are seen in IDLE.
- gnt is glitch-free, driven directly from flops.
- gnt_idx is consistent with gnt on every cycle.
- preempt=1 implies gnt_valid=0 on the same cycle.
- Invariants checked by the bench:
  - popcount(gnt) ≤ 1.
  - gnt_valid == |gnt.
  - No owner holds gnt for more than MAX_HOLD consecutive cycles when MAX_HOLD != 0.

Test Plan:
- Reset: hold rst_n=0 with req=8'hFF, toggle clk → gnt=0, gnt_valid=0, preempt=0; any_req=1. Release reset → gnt=8'h01, gnt_idx=0 one cycle later.
- Single requester: req=8'h10 held 5 cycles, then 0 → gnt=8'h10 for 5 cycles, gnt_idx=4; next cycle gnt=0 (GAP); ptr becomes 5.
- Round-robin fairness: req=8'hFF, each owner drops req for 1 cycle after 2 cycles of ownership → grant order 0,1,2,...,7,0. Each grant is separated by exactly 2 cycles with gnt=0.
- Preemption, MAX_HOLD=4: req=8'h06 held constant → gnt=8'h02 for 4 cycles, then preempt pulse with gnt=0. gnt=8'h04 for 4 cycles, then preempt, then 8'h02 again.
- Wrap and unlimited hold, MAX_HOLD=0: ptr=7 after owner 6 releases, req=8'h81 → gnt=8'h80. Hold for 300 cycles: no preempt and no release. Drop req[7] → gnt=0, then gnt=8'h01.
- Async reset mid-grant: while gnt=8'h08, pulse rst_n low between clock edges → gnt=0 before the next edge. After release, req=8'h08 is granted again with ptr=0 ordering.
